// File: rtl/row_result_collector_pkg.sv
// Sizing defaults and collector state encoding shared by the organizer,
// the row result collector and the solver control.
package row_result_collector_pkg;

  localparam int def_element_width  = 32;
  localparam int def_no_of_rows     = 64;
  localparam int def_row_addr_width = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } collect_state_t;

  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/row_result_collector_chunk_counter.sv
// Modulo-chunks_per_row strobe counter; last_chunk marks the strobe that
// carries a complete row sum.
module row_chunk_counter #(
  parameter int chunks_per_row  = 4,
  parameter int chunk_cnt_width = 2
) (
  input  logic clk,
  input  logic main_reset,
  input  logic clear,
  input  logic advance,
  output logic last_chunk
);

  localparam logic [chunk_cnt_width-1:0] last_val = chunk_cnt_width'(chunks_per_row - 1);

  logic [chunk_cnt_width-1:0] count_q, count_d;

  assign last_chunk = (count_q == last_val);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (advance) begin
      count_d = last_chunk ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (main_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/row_result_collector.sv
// Keeps the final accumulated sum of each matrix row and packs the row sums
// into a flat vector plus a registered read port for the solver stage.
//
//   state      | meaning
//   ST_IDLE    | waiting for start; strobes ignored
//   ST_COLLECT | counting chunk strobes, storing every last-chunk sum
//   ST_DONE    | all rows captured; further strobes flag overflow
module row_result_collector
  import row_result_collector_pkg::*;
#(
  parameter int element_width   = def_element_width,
  parameter int no_of_rows      = def_no_of_rows,
  parameter int row_addr_width  = def_row_addr_width,
  parameter int chunks_per_row  = 4,
  parameter int chunk_cnt_width = 2
) (
  input  logic                              clk,
  input  logic                              main_reset,
  input  logic                              start,
  input  logic [element_width-1:0]          result_data,
  input  logic                              result_valid,
  input  logic [row_addr_width-1:0]         read_addr,
  output logic [element_width-1:0]          read_data,
  output logic [no_of_rows*element_width-1:0] collected_vector,
  output logic [row_addr_width-1:0]         row_index,
  output logic                              collect_done,
  output logic                              overflow_error
);

  localparam logic [row_addr_width-1:0] last_row  = row_addr_width'(no_of_rows - 1);
  localparam logic [row_addr_width:0]   row_limit = (row_addr_width + 1)'(no_of_rows);

  collect_state_t                       state_q, state_d;
  logic [row_addr_width-1:0]            row_index_q, row_index_d;
  logic [no_of_rows*element_width-1:0]  vector_q, vector_d;
  logic [element_width-1:0]             read_data_q, read_data_d;
  logic                                 done_q, done_d;
  logic                                 overflow_q, overflow_d;
  logic                                 counting, last_chunk, store;

  // The chunk counter only runs while collecting with start held; any other
  // state or a dropped start parks it at zero for the next pass.
  assign counting = (state_q == ST_COLLECT) && start;
  assign store    = counting && result_valid && last_chunk;

  row_chunk_counter #(
    .chunks_per_row (chunks_per_row),
    .chunk_cnt_width(chunk_cnt_width)
  ) u_chunk_counter (
    .clk       (clk),
    .main_reset(main_reset),
    .clear     (!counting),
    .advance   (counting && result_valid),
    .last_chunk(last_chunk)
  );

  always_comb begin
    state_d     = state_q;
    row_index_d = row_index_q;
    vector_d    = vector_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_COLLECT;
          row_index_d = '0;
        end
      end
      ST_COLLECT: begin
        if (!start) begin
          state_d     = ST_IDLE;
          row_index_d = '0;
          done_d      = 1'b0;
        end else if (store) begin
          vector_d[slot_lsb(int'(row_index_q), element_width) +: element_width] = result_data;
          if (row_index_q == last_row) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            row_index_d = row_index_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d     = ST_IDLE;
          row_index_d = '0;
          done_d      = 1'b0;
        end else if (result_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads see the pre-write contents, so a same-cycle write shows up one read later.
  always_comb begin
    read_data_d = '0;
    if ({1'b0, read_addr} < row_limit) begin
      read_data_d = vector_q[slot_lsb(int'(read_addr), element_width) +: element_width];
    end
  end

  always_ff @(posedge clk) begin
    if (main_reset) begin
      state_q     <= ST_IDLE;
      row_index_q <= '0;
      vector_q    <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_index_q <= row_index_d;
      vector_q    <= vector_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign read_data        = read_data_q;
  assign collected_vector = vector_q;
  assign row_index        = row_index_q;
  assign collect_done     = done_q;
  assign overflow_error   = overflow_q;

endmodule

// File: tb/tb_row_result_collector.sv
// Directed bench for row_result_collector: a four-chunk instance with a wide
// read address and a single-chunk instance, checked against a scoreboard.
module tb_row_result_collector;
  import row_result_collector_pkg::*;

  localparam int ew = 32;
  localparam int nr = 64;

  logic clk = 1'b0;
  logic main_reset;

  logic              start0, rv0;
  logic [ew-1:0]     rdata0, rd0;
  logic [6:0]        raddr0, ridx0;
  logic [nr*ew-1:0]  vec0;
  logic              done0, ovf0;

  logic              start1, rv1;
  logic [ew-1:0]     rdata1, rd1;
  logic [5:0]        raddr1, ridx1;
  logic [nr*ew-1:0]  vec1;
  logic              done1, ovf1;

  always #5 clk = ~clk;

  row_result_collector #(
    .element_width(ew), .no_of_rows(nr), .row_addr_width(7),
    .chunks_per_row(4), .chunk_cnt_width(2)
  ) dut0 (
    .clk(clk), .main_reset(main_reset), .start(start0),
    .result_data(rdata0), .result_valid(rv0), .read_addr(raddr0),
    .read_data(rd0), .collected_vector(vec0), .row_index(ridx0),
    .collect_done(done0), .overflow_error(ovf0)
  );

  row_result_collector #(
    .element_width(ew), .no_of_rows(nr), .row_addr_width(6),
    .chunks_per_row(1), .chunk_cnt_width(1)
  ) dut1 (
    .clk(clk), .main_reset(main_reset), .start(start1),
    .result_data(rdata1), .result_valid(rv1), .read_addr(raddr1),
    .read_data(rd1), .collected_vector(vec1), .row_index(ridx1),
    .collect_done(done1), .overflow_error(ovf1)
  );

  typedef struct {
    int          d;
    int          slot;
    logic [31:0] val;
  } sb_t;

  sb_t              sb_q[$];
  int               checks = 0;
  int               failures = 0;
  logic [nr*ew-1:0] exp_vec [2];
  int               exp_row [2];
  int               exp_chunk [2];
  int               exp_state [2];
  logic             exp_done [2];
  logic             exp_ovf [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [nr*ew-1:0] obs, input logic [nr*ew-1:0] exp);
    int bad;
    bad = -1;
    for (int s = nr - 1; s >= 0; s--)
      if (obs[s*ew +: ew] !== exp[s*ew +: ew]) bad = s;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s first bad slot %0d observed=%h expected=%h", tag, bad,
             obs[bad*ew +: ew], exp[bad*ew +: ew]);
    end
  endtask

  task automatic model_reset(input int d);
    exp_vec[d]   = '0;
    exp_row[d]   = 0;
    exp_chunk[d] = 0;
    exp_state[d] = 0;
    exp_done[d]  = 1'b0;
    exp_ovf[d]   = 1'b0;
  endtask

  task automatic model_restart(input int d);
    exp_row[d]   = 0;
    exp_chunk[d] = 0;
    exp_state[d] = 1;
    exp_done[d]  = 1'b0;
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = (e.d == 0) ? vec0[e.slot*ew +: ew] : vec1[e.slot*ew +: ew];
      chk($sformatf("dut%0d_slot%0d", e.d, e.slot), obs, e.val);
    end
  endtask

  // One strobe with start held high; model updated, then output scored.
  task automatic strobe(input int d, input logic [31:0] data);
    int cpr;
    cpr = (d == 0) ? 4 : 1;
    if (d == 0) begin rv0 = 1'b1; rdata0 = data; end
    else        begin rv1 = 1'b1; rdata1 = data; end
    if (exp_state[d] == 1) begin
      if (exp_chunk[d] == cpr - 1) begin
        exp_vec[d][exp_row[d]*ew +: ew] = data;
        sb_q.push_back('{d, exp_row[d], data});
        exp_chunk[d] = 0;
        if (exp_row[d] == nr - 1) begin
          exp_state[d] = 2;
          exp_done[d]  = 1'b1;
        end else begin
          exp_row[d]++;
        end
      end else begin
        exp_chunk[d]++;
      end
    end else if (exp_state[d] == 2) begin
      exp_ovf[d] = 1'b1;
    end
    tick();
    rv0 = 1'b0;
    rv1 = 1'b0;
    drain();
  endtask

  initial begin
    logic [31:0] old_val;
    main_reset = 1'b1;
    start0 = 1'b0; rv0 = 1'b0; rdata0 = '0; raddr0 = '0;
    start1 = 1'b0; rv1 = 1'b0; rdata1 = '0; raddr1 = '0;
    model_reset(0);
    model_reset(1);
    tick();
    tick();
    main_reset = 1'b0;

    chk("rst_row_index", 32'(ridx0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_overflow", 32'(ovf0), 32'd0);
    chk("rst_read_data", rd0, 32'd0);
    chk_vec("rst_vector", vec0, exp_vec[0]);

    // Ten rows, part of an eleventh, then reset with a completing strobe.
    start0 = 1'b1;
    tick();
    model_restart(0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 4; c++) strobe(0, 32'(r*4 + c));
    for (int c = 0; c < 3; c++) strobe(0, 32'(40 + c));
    chk("row_index_after_10", 32'(ridx0), 32'd10);
    chk("read_slot0_before_rst", rd0, 32'd3);
    main_reset = 1'b1;
    rv0 = 1'b1;
    rdata0 = 32'hFFFF_FFFF;
    tick();
    main_reset = 1'b0;
    rv0 = 1'b0;
    model_reset(0);
    chk_vec("midrst_vector", vec0, exp_vec[0]);
    chk("midrst_row_index", 32'(ridx0), 32'd0);
    chk("midrst_state", 32'(int'(dut0.state_q)), 32'd0);
    chk("midrst_read_data", rd0, 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);

    // Full pass: 256 back-to-back strobes.
    tick();
    model_restart(0);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < 4; c++) begin
        if (r == nr - 1 && c == 3) chk("done_before_last", 32'(done0), 32'd0);
        strobe(0, 32'(r*4 + c));
      end
    chk("done_after_last", 32'(done0), 32'd1);
    chk("row_index_saturated", 32'(ridx0), 32'd63);
    chk("state_done", 32'(int'(dut0.state_q)), 32'd2);
    chk_vec("full_vector", vec0, exp_vec[0]);

    // Strobe in DONE: sticky overflow, buffer untouched, no restart.
    strobe(0, 32'hDEAD_BEEF);
    chk("overflow_set", 32'(ovf0), 32'(exp_ovf[0]));
    chk("done_held", 32'(done0), 32'd1);
    chk_vec("overflow_vector", vec0, exp_vec[0]);
    tick(); tick(); tick();
    chk("overflow_sticky", 32'(ovf0), 32'd1);
    chk("no_restart_state", 32'(int'(dut0.state_q)), 32'd2);

    // Drop start, new partial pass, drop start with a coincident strobe.
    start0 = 1'b0;
    tick();
    exp_state[0] = 0; exp_row[0] = 0; exp_chunk[0] = 0; exp_done[0] = 1'b0;
    chk("drop_row_index", 32'(ridx0), 32'd0);
    chk("drop_done", 32'(done0), 32'd0);
    chk("drop_overflow_kept", 32'(ovf0), 32'd1);
    chk_vec("drop_vector_kept", vec0, exp_vec[0]);
    start0 = 1'b1;
    tick();
    model_restart(0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        strobe(0, (c == 3) ? ((r == 4) ? 32'h40A0_0000 : 32'h2000_0000 + 32'(r))
                           : 32'h2100_0000 + 32'(r*4 + c));
    start0 = 1'b0;
    rv0 = 1'b1;
    rdata0 = 32'h1234_5678;
    tick();
    rv0 = 1'b0;
    exp_state[0] = 0; exp_row[0] = 0; exp_chunk[0] = 0;
    chk("coincident_state", 32'(int'(dut0.state_q)), 32'd0);
    chk_vec("coincident_vector", vec0, exp_vec[0]);
    start0 = 1'b1;
    tick();
    model_restart(0);
    chk("restart_row_index", 32'(ridx0), 32'd0);
    chk("slot4_retained", vec0[4*ew +: ew], 32'h40A0_0000);
    for (int c = 0; c < 4; c++) strobe(0, 32'hAAAA_0000 + 32'(c));
    chk("slot0_rewritten", vec0[0 +: ew], 32'hAAAA_0003);
    chk("slot4_untouched", vec0[4*ew +: ew], 32'h40A0_0000);
    chk("row_index_one", 32'(ridx0), 32'd1);

    // Read port: old value during the write edge, new value one cycle later.
    raddr0 = 7'd3;
    for (int r = 1; r < 3; r++)
      for (int c = 0; c < 4; c++) strobe(0, 32'h5000_0000 + 32'(r*4 + c));
    for (int c = 0; c < 3; c++) strobe(0, 32'h5100_0000 + 32'(c));
    old_val = exp_vec[0][3*ew +: ew];
    strobe(0, 32'h3F80_0000);
    chk("read_same_cycle_old", rd0, old_val);
    tick();
    chk("read_next_cycle_new", rd0, 32'h3F80_0000);
    raddr0 = 7'd64;
    tick();
    chk("read_addr_64", rd0, 32'd0);
    raddr0 = 7'd63;
    tick();
    chk("read_addr_63", rd0, exp_vec[0][63*ew +: ew]);
    raddr0 = 7'd127;
    tick();
    chk("read_addr_127", rd0, 32'd0);

    // Single-chunk instance: every strobe stores, back to back.
    start1 = 1'b1;
    tick();
    model_restart(1);
    for (int i = 0; i < nr; i++) begin
      if (i == nr - 1) chk("c1_done_before_last", 32'(done1), 32'd0);
      strobe(1, 32'hC000_0000 | 32'(i));
    end
    chk("c1_done_after_last", 32'(done1), 32'd1);
    chk("c1_row_index", 32'(ridx1), 32'd63);
    chk_vec("c1_vector", vec1, exp_vec[1]);
    raddr1 = 6'd5;
    tick();
    chk("c1_read_slot5", rd1, 32'hC000_0005);
    strobe(1, 32'h1111_1111);
    chk("c1_overflow", 32'(ovf1), 32'd1);
    chk_vec("c1_vector_after_ovf", vec1, exp_vec[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
